dac_sample_streamer: RTL and testbench
======================================

// Module: dac_sample_streamer
// PURPOSE
//   Sample path between the plb_dac slave registers and the 10-bit parallel DAC pins.
//   Buffers two's-complement samples in a FIFO.
//   Replays them at a programmable rate, with format conversion, on S_Data/S_DCLKIO.
//   Reports FIFO level and underrun back to the register bank.
// PARAMETERS
//   C_DATA_WIDTH   10  DAC sample width (bits)
//   C_FIFO_DEPTH   16  sample FIFO depth; power of 2, >= 4
//   C_PRIME_LEVEL  4   FIFO level required before playback starts; 1..C_FIFO_DEPTH
//   C_DIV_WIDTH    16  width of sample-period divider
// PORTS
//   Bus2IP_Clk    in   1                     system clock, all logic rising-edge
//   Bus2IP_Reset  in   1                     asynchronous, active-high reset
//   wr_data       in   C_DATA_WIDTH          sample, two's complement
//   wr_valid      in   1                     sample offered
//   wr_ready      out  1                     FIFO not full; push when valid&ready
//   fifo_flush    in   1                     single-cycle pulse: empty FIFO
//   enable        in   1                     playback enable
//   pwrdn_req     in   1                     DAC power-down request
//   fmt_twos      in   1                     1: drive two's complement; 0: offset binary
//   div_value     in   C_DIV_WIDTH           sample period = div_value+1 clocks; 0 acts as 1
//   underrun_clr  in   1                     clears sticky underrun
//   fifo_level    out  clog2(C_FIFO_DEPTH)+1 current occupancy, 0..C_FIFO_DEPTH
//   underrun      out  1                     sticky: sample slot with empty FIFO
//   S_Data        out  C_DATA_WIDTH          DAC data, registered
//   S_DCLKIO      out  1                     DAC latch clock; DAC samples on rising edge
//   S_Format      out  1                     registered copy of latched format
//   S_PWRDN       out  1                     DAC power-down, registered
// BEHAVIOUR
//   Reset values:
//   - Outputs: S_Data=0x200, S_DCLKIO=0, S_Format=0, S_PWRDN=1, underrun=0.
//   - FIFO empty; fifo_level=0, wr_ready=1; state IDLE.
//   FIFO
//   - wr_ready = (level < C_FIFO_DEPTH), independent of same-cycle pop.
//   - Push and pop in the same cycle: level unchanged.
//   - Pointers wrap modulo depth.
//   - fifo_flush empties the FIFO and overrides a same-cycle push or pop.
//   - fifo_level is registered and updates the cycle after a push or pop.
//   Formatting
//   - Offset binary = two's complement with MSB inverted.
//   - Midscale code: 0x200 in offset binary, 0x000 in two's complement.
//   States
//   - IDLE:  S_DCLKIO=0; S_Data=midscale of current fmt_twos; S_Format=fmt_twos.
//            Go to PRIME when enable=1 and pwrdn_req=0.
//   - PRIME: outputs as in IDLE.
//            Go to RUN on the cycle when fifo_level >= C_PRIME_LEVEL.
//            On RUN entry, latch fmt_twos and div_value and set cnt=0.
//   - RUN:   cnt counts 0..D (D = max(div_value,1)), then wraps to 0.
//            On the edge where cnt==0:
//              - FIFO non-empty: pop, S_Data <= formatted head, S_DCLKIO <= 0.
//              - FIFO empty (includes same-cycle push): S_Data holds, S_DCLKIO <= 0, underrun <= 1.
//            On the edge where cnt==(D+1)>>1: S_DCLKIO <= 1.
//            On the edge where cnt==D: re-latch div_value; fmt_twos stays frozen.
//   - Leaving RUN/PRIME: enable=0 or pwrdn_req=1 returns to IDLE on the next edge.
//            S_DCLKIO <= 0 and S_Data <= midscale; the FIFO is not flushed.
//   Latency and timing
//   - First S_Data update: 1 clock after RUN entry.
//   - First rising edge of S_DCLKIO: (D+1)>>1 clocks after that.
//   Other outputs
//   - S_PWRDN <= pwrdn_req every cycle, 1-cycle latency.
//   - underrun: set has priority over underrun_clr in the same cycle; otherwise clr -> 0.
//   - Asynchronous reset mid-RUN: all state and outputs return to reset values immediately.
// TESTING
//   1. Reset, fmt_twos=0, enable=1, div_value=3, push 4 samples 0x000,0x001,0x1FF,0x200
//      -> S_Data = 0x200,0x201,0x3FF,0x000, one per 4 clocks.
//      -> S_DCLKIO low 2 clocks, high 2 clocks.
//   2. Push 16 samples without enable -> wr_ready=0 and fifo_level=16.
//      17th push is refused; FIFO contents unchanged.
//   3. RUN with 4 samples, no further pushes -> 5th slot: underrun=1, S_Data repeats the last sample.
//      Assert underrun_clr -> underrun=0.
//   4. div_value=0, fmt_twos=1 -> period 2 clocks, S_DCLKIO toggles every clock.
//      S_Data equals raw samples; S_Format=1.
//   5. pwrdn_req=1 mid-RUN -> next edge: IDLE, S_Data=midscale, S_DCLKIO=0.
//      S_PWRDN=1 one cycle later; fifo_level unchanged.
//   6. Assert Bus2IP_Reset mid-RUN for 1 cycle -> all outputs take reset values at once, FIFO empty.

Source files
------------

// File: rtl/dac_sample_streamer.sv
// dac_sample_streamer
//   Sample path from the plb_dac register bank to the 10-bit parallel DAC.
//   Two's-complement samples are buffered in a FIFO. Once the FIFO holds
//   C_PRIME_LEVEL samples, they are replayed at one sample per (D+1) clocks,
//   where D = max(div_value, 1). The DAC sees offset binary or two's
//   complement data plus a latch clock.
//
// Ports
//   Bus2IP_Clk, Bus2IP_Reset   clock, asynchronous active-high reset
//   wr_data/wr_valid/wr_ready  sample push interface (valid & ready)
//   fifo_flush                 one-cycle pulse, empties the FIFO
//   enable, pwrdn_req          playback enable / DAC power-down request
//   fmt_twos                   1: two's complement out, 0: offset binary
//   div_value                  sample period = max(div_value,1)+1 clocks
//   underrun_clr               clears the sticky underrun flag
//   fifo_level, underrun       status back to the register bank
//   S_Data, S_DCLKIO,          registered DAC pins
//   S_Format, S_PWRDN
module dac_sample_streamer #(
    parameter int C_DATA_WIDTH  = 10,
    parameter int C_FIFO_DEPTH  = 16,
    parameter int C_PRIME_LEVEL = 4,
    parameter int C_DIV_WIDTH   = 16
) (
    input  logic                            Bus2IP_Clk,
    input  logic                            Bus2IP_Reset,
    input  logic [C_DATA_WIDTH-1:0]         wr_data,
    input  logic                            wr_valid,
    output logic                            wr_ready,
    input  logic                            fifo_flush,
    input  logic                            enable,
    input  logic                            pwrdn_req,
    input  logic                            fmt_twos,
    input  logic [C_DIV_WIDTH-1:0]          div_value,
    input  logic                            underrun_clr,
    output logic [$clog2(C_FIFO_DEPTH):0]   fifo_level,
    output logic                            underrun,
    output logic [C_DATA_WIDTH-1:0]         S_Data,
    output logic                            S_DCLKIO,
    output logic                            S_Format,
    output logic                            S_PWRDN
);

    localparam int AW = $clog2(C_FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [C_DATA_WIDTH-1:0] MSB = {1'b1, {(C_DATA_WIDTH-1){1'b0}}};

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    // Offset binary is two's complement with the MSB inverted; midscale is
    // simply the conversion of zero.
    function automatic logic [C_DATA_WIDTH-1:0] fmt_conv(
        input logic [C_DATA_WIDTH-1:0] s,
        input logic                    twos
    );
        return twos ? s : (s ^ MSB);
    endfunction

    // ------------------------------------------------------------------
    // Sample FIFO
    // ------------------------------------------------------------------
    logic [C_DATA_WIDTH-1:0] mem [C_FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic                    push, pop, fifo_empty;

    assign wr_ready   = (fifo_level < LW'(C_FIFO_DEPTH));
    assign fifo_empty = (fifo_level == '0);
    assign push       = wr_valid & wr_ready;

    always_ff @(posedge Bus2IP_Clk) begin
        if (push && !fifo_flush)
            mem[wr_ptr] <= wr_data;
    end

    // Depth is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
        if (Bus2IP_Reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else if (fifo_flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Playback sequencer
    // ------------------------------------------------------------------
    logic [1:0]             state;
    logic [C_DIV_WIDTH-1:0] cnt, div_lat, div_eff, half;
    logic [C_DIV_WIDTH:0]   d_p1;
    logic                   fmt_lat, run_ok, slot;

    assign run_ok  = enable & ~pwrdn_req;
    assign div_eff = (div_lat == '0) ? C_DIV_WIDTH'(1) : div_lat;
    // (D+1)>>1 computed one bit wider so D = all-ones does not overflow.
    assign d_p1    = {1'b0, div_eff} + {{C_DIV_WIDTH{1'b0}}, 1'b1};
    assign half    = d_p1[C_DIV_WIDTH:1];
    // A sample slot is suppressed on the cycle we drop out of RUN.
    assign slot    = (state == ST_RUN) && run_ok && (cnt == '0);
    assign pop     = slot && !fifo_empty;

    always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
        if (Bus2IP_Reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            div_lat  <= '0;
            fmt_lat  <= 1'b0;
            S_Data   <= MSB;
            S_DCLKIO <= 1'b0;
            S_Format <= 1'b0;
        end else if (state == ST_RUN && run_ok) begin
            S_Format <= fmt_lat;
            if (cnt == '0) begin
                S_DCLKIO <= 1'b0;
                if (!fifo_empty)
                    S_Data <= fmt_conv(mem[rd_ptr], fmt_lat);
            end
            // half is never 0, so it cannot collide with the slot edge.
            if (cnt == half)
                S_DCLKIO <= 1'b1;
            if (cnt == div_eff) begin
                cnt     <= '0;
                div_lat <= div_value;
            end else begin
                cnt <= cnt + C_DIV_WIDTH'(1);
            end
        end else begin
            // IDLE, PRIME, or leaving RUN: park the DAC at midscale.
            S_DCLKIO <= 1'b0;
            S_Data   <= fmt_conv('0, fmt_twos);
            S_Format <= fmt_twos;
            if (!run_ok) begin
                state <= ST_IDLE;
            end else if (state == ST_PRIME &&
                         fifo_level >= LW'(C_PRIME_LEVEL)) begin
                state   <= ST_RUN;
                cnt     <= '0;
                div_lat <= div_value;
                fmt_lat <= fmt_twos;
            end else begin
                state <= ST_PRIME;
            end
        end
    end

    // ------------------------------------------------------------------
    // Status / power-down
    // ------------------------------------------------------------------
    always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
        if (Bus2IP_Reset) begin
            underrun <= 1'b0;
            S_PWRDN  <= 1'b1;
        end else begin
            S_PWRDN <= pwrdn_req;
            // A new underrun wins over a same-cycle clear.
            if (slot && fifo_empty)
                underrun <= 1'b1;
            else if (underrun_clr)
                underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dac_sample_streamer.sv
// Self-checking bench for dac_sample_streamer: table of playback vectors,
// hand-written corner sequences, and a randomized run checked against a
// queue model of what the DAC latches on each S_DCLKIO rising edge.
module tb_dac_sample_streamer;

    localparam int W  = 10;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  wr_data;
    logic          wr_valid, wr_ready, fifo_flush, enable, pwrdn_req, fmt_twos;
    logic [DW-1:0] div_value;
    logic          underrun_clr, underrun, S_DCLKIO, S_Format, S_PWRDN;
    logic [4:0]    fifo_level;
    logic [W-1:0]  S_Data;

    always #5 clk = ~clk;

    dac_sample_streamer dut (
        .Bus2IP_Clk(clk), .Bus2IP_Reset(rst),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .fifo_flush(fifo_flush), .enable(enable), .pwrdn_req(pwrdn_req),
        .fmt_twos(fmt_twos), .div_value(div_value), .underrun_clr(underrun_clr),
        .fifo_level(fifo_level), .underrun(underrun), .S_Data(S_Data),
        .S_DCLKIO(S_DCLKIO), .S_Format(S_Format), .S_PWRDN(S_PWRDN)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_valid = 1'b0; wr_data = '0; fifo_flush = 1'b0;
        enable = 1'b0; pwrdn_req = 1'b0; fmt_twos = 1'b0; div_value = '0;
        underrun_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic push(input logic [W-1:0] d);
        wr_data = d; wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
    endtask

    // Offset binary = two's complement shifted up by half range (mod 2^W).
    function automatic logic [W-1:0] fmt_ref(input logic [W-1:0] s, input logic twos);
        logic [W-1:0] half_range;
        half_range = 10'h200;
        return twos ? s : s + half_range;
    endfunction

    function automatic logic [W-1:0] mid_ref(input logic twos);
        return twos ? 10'h000 : 10'h200;
    endfunction

    typedef struct packed {
        logic                fmt;
        logic [7:0]          div;
        logic [3:0][W-1:0]   s;
        logic [3:0][W-1:0]   e;
    } vec_t;

    function automatic vec_t mk(input logic f, input logic [7:0] dv,
                                input logic [W-1:0] s0, s1, s2, s3,
                                input logic [W-1:0] e0, e1, e2, e3);
        vec_t v;
        v.fmt = f; v.div = dv;
        v.s[0] = s0; v.s[1] = s1; v.s[2] = s2; v.s[3] = s3;
        v.e[0] = e0; v.e[1] = e1; v.e[2] = e2; v.e[3] = e3;
        return v;
    endfunction

    vec_t         vt[4];
    logic [W-1:0] dq[16];
    logic [W-1:0] q[$];
    logic [W-1:0] x;
    logic [4:0]   lvl;
    logic         f0, prev;
    int           p, h, d, nrise, cyc, last_rise;

    initial begin
        vt[0] = mk(1'b0, 8'd3, 10'h000, 10'h001, 10'h1FF, 10'h200,
                               10'h200, 10'h201, 10'h3FF, 10'h000);
        vt[1] = mk(1'b1, 8'd0, 10'h123, 10'h3FF, 10'h000, 10'h200,
                               10'h123, 10'h3FF, 10'h000, 10'h200);
        vt[2] = mk(1'b0, 8'd1, 10'h3FF, 10'h200, 10'h155, 10'h0AA,
                               10'h1FF, 10'h000, 10'h355, 10'h2AA);
        vt[3] = mk(1'b1, 8'd5, 10'h001, 10'h002, 10'h003, 10'h3FE,
                               10'h001, 10'h002, 10'h003, 10'h3FE);

        // ---- reset values ----
        do_reset();
        check("rst_S_Data",   32'(S_Data), 32'h200);
        check("rst_S_DCLKIO", 32'(S_DCLKIO), 32'd0);
        check("rst_S_Format", 32'(S_Format), 32'd0);
        check("rst_S_PWRDN",  32'(S_PWRDN), 32'd1);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_level",    32'(fifo_level), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);

        // ---- flush overrides a same-cycle push ----
        push(10'h011); push(10'h022); push(10'h033);
        check("flush_pre_level", 32'(fifo_level), 32'd3);
        fifo_flush = 1'b1; wr_valid = 1'b1; wr_data = 10'h044;
        tick();
        fifo_flush = 1'b0; wr_valid = 1'b0;
        check("flush_level", 32'(fifo_level), 32'd0);

        // ---- table-driven playback vectors ----
        for (int r = 0; r < 4; r++) begin
            do_reset();
            fmt_twos  = vt[r].fmt;
            div_value = DW'(vt[r].div);
            for (int i = 0; i < 4; i++) push(vt[r].s[i]);
            check("vec_level", 32'(fifo_level), 32'd4);
            p = ((vt[r].div == 8'd0) ? 1 : int'(vt[r].div)) + 1;
            h = p / 2;
            enable = 1'b1;
            tick();                                   // IDLE -> PRIME
            check("vec_prime_data", 32'(S_Data), 32'(mid_ref(vt[r].fmt)));
            check("vec_prime_dclk", 32'(S_DCLKIO), 32'd0);
            tick();                                   // PRIME -> RUN
            for (int j = 0; j < 4 * p; j++) begin
                tick();
                check("vec_data", 32'(S_Data), 32'(vt[r].e[j / p]));
                check("vec_dclk", 32'(S_DCLKIO), ((j % p) >= h) ? 32'd1 : 32'd0);
            end
            check("vec_format", 32'(S_Format), 32'(vt[r].fmt));
            tick();                                   // fifth slot, FIFO empty
            check("vec_underrun",  32'(underrun), 32'd1);
            check("vec_hold_data", 32'(S_Data), 32'(vt[r].e[3]));
            check("vec_ur_dclk",   32'(S_DCLKIO), 32'd0);
            enable = 1'b0; underrun_clr = 1'b1;
            tick();
            underrun_clr = 1'b0;
            check("vec_ur_clr",    32'(underrun), 32'd0);
            check("vec_idle_data", 32'(S_Data), 32'(mid_ref(vt[r].fmt)));
            check("vec_idle_dclk", 32'(S_DCLKIO), 32'd0);
        end

        // ---- full FIFO: 17th push refused, contents intact ----
        do_reset();
        fmt_twos = 1'b1; div_value = '0;
        for (int i = 0; i < 16; i++) begin
            dq[i] = W'(i * 37 + 5);
            push(dq[i]);
        end
        check("full_wr_ready", 32'(wr_ready), 32'd0);
        check("full_level",    32'(fifo_level), 32'd16);
        wr_valid = 1'b1; wr_data = 10'h3AB;
        tick();
        wr_valid = 1'b0;
        check("full_level_17", 32'(fifo_level), 32'd16);
        enable = 1'b1;
        tick(); tick();
        for (int k = 0; k < 16; k++) begin
            tick();
            check("full_data", 32'(S_Data), 32'(dq[k]));
            if (k == 0) check("full_ready_after_pop", 32'(wr_ready), 32'd1);
            tick();
        end
        tick();
        check("full_underrun", 32'(underrun), 32'd1);
        check("full_no_17th",  32'(S_Data), 32'(dq[15]));
        enable = 1'b0;
        tick();

        // ---- power-down request mid-RUN ----
        do_reset();
        div_value = DW'(3);
        for (int i = 0; i < 6; i++) push(W'(i + 1));
        enable = 1'b1;
        tick(); tick(); tick(); tick();
        check("pd_pwrdn_low", 32'(S_PWRDN), 32'd0);
        check("pd_run_data",  32'(S_Data), 32'h201);
        pwrdn_req = 1'b1;
        tick();
        check("pd_data",  32'(S_Data), 32'h200);
        check("pd_dclk",  32'(S_DCLKIO), 32'd0);
        check("pd_pwrdn", 32'(S_PWRDN), 32'd1);
        check("pd_level", 32'(fifo_level), 32'd5);
        tick();
        check("pd_level_hold", 32'(fifo_level), 32'd5);
        pwrdn_req = 1'b0;

        // ---- asynchronous reset mid-RUN ----
        do_reset();
        div_value = DW'(3);
        push(10'h155);
        for (int i = 0; i < 4; i++) push(W'(i));
        enable = 1'b1;
        tick(); tick(); tick();
        check("ar_run_data", 32'(S_Data), 32'h355);
        #2 rst = 1'b1;
        #1;
        check("ar_S_Data",   32'(S_Data), 32'h200);
        check("ar_S_DCLKIO", 32'(S_DCLKIO), 32'd0);
        check("ar_S_PWRDN",  32'(S_PWRDN), 32'd1);
        check("ar_underrun", 32'(underrun), 32'd0);
        check("ar_level",    32'(fifo_level), 32'd0);
        check("ar_wr_ready", 32'(wr_ready), 32'd1);
        enable = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        // ---- randomized playback vs. queue model of DAC latches ----
        for (int rnd = 0; rnd < 4; rnd++) begin
            do_reset();
            f0 = 1'($urandom_range(1, 0));
            d  = int'($urandom_range(6, 0));
            p  = ((d == 0) ? 1 : d) + 1;
            fmt_twos = f0; div_value = DW'(d); enable = 1'b1;
            q.delete(); nrise = 0; cyc = 0; prev = 1'b0; last_rise = 0;
            while (nrise < 30 && cyc < 2000) begin
                if (S_DCLKIO && !prev) begin
                    if (q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL rnd_capture: DAC latched %0h with no sample outstanding", S_Data);
                    end else begin
                        x = q.pop_front();
                        check("rnd_data", 32'(S_Data), 32'(x));
                    end
                    check("rnd_format", 32'(S_Format), 32'(f0));
                    if (nrise > 0) check("rnd_period", 32'(cyc - last_rise), 32'(p));
                    last_rise = cyc;
                    nrise++;
                end
                prev = S_DCLKIO;
                // Format must stay frozen once playback is under way.
                if (nrise > 0) fmt_twos = 1'($urandom_range(1, 0));
                wr_data  = W'($urandom_range(1023, 0));
                wr_valid = (fifo_level < 5'd8) || ($urandom_range(3, 0) != 0);
                if (wr_valid && wr_ready) q.push_back(fmt_ref(wr_data, f0));
                tick();
                cyc++;
            end
            if (nrise < 30) begin
                total++; bad++;
                $display("FAIL rnd_timeout: saw %0d latch edges, required 30", nrise);
            end
            check("rnd_underrun", 32'(underrun), 32'd0);
            enable = 1'b0; wr_valid = 1'b0;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
